// File: rtl/ctrl_pkg.sv
// Shared encodings for the multi-cycle control FSM: states, PC source select,
// MDU operation and the bit positions of the instruction class register.
package ctrl_pkg;

    typedef enum logic [2:0] {
        ST_FETCH  = 3'd0,
        ST_DECODE = 3'd1,
        ST_EXEC   = 3'd2,
        ST_MEM    = 3'd3,
        ST_WB     = 3'd4,
        ST_MDU    = 3'd5,
        ST_TRAP   = 3'd6
    } state_t;

    typedef enum logic [1:0] {
        PC_SRC_PC4 = 2'd0,
        PC_SRC_BR  = 2'd1,
        PC_SRC_J   = 2'd2,
        PC_SRC_RS  = 2'd3
    } pc_src_t;

    typedef enum logic {
        MDU_OP_MULT = 1'b0,
        MDU_OP_DIV  = 1'b1
    } mdu_op_t;

    localparam int CLS_W      = 9;
    localparam int CLS_ALU    = 0;
    localparam int CLS_LOAD   = 1;
    localparam int CLS_STORE  = 2;
    localparam int CLS_BRANCH = 3;
    localparam int CLS_JAL    = 4;
    localparam int CLS_JR     = 5;
    localparam int CLS_MULT   = 6;
    localparam int CLS_DIV    = 7;
    localparam int CLS_MFHILO = 8;

    function automatic logic [CLS_W-1:0] cls_oh(input int idx);
        logic [CLS_W-1:0] v;
        v = '0;
        v[idx] = 1'b1;
        return v;
    endfunction

    function automatic logic is_onehot(input logic [CLS_W-1:0] f);
        return (f != '0) && ((f & (f - CLS_W'(1))) == '0);
    endfunction

endpackage

// File: rtl/mc_ctrl_fsm_mdu_wait_counter.sv
// Down-counter that times the MULT/DIV wait: loaded on MDU start, decremented
// once per wait cycle, and flags zero on the cycle the result is ready.
module mdu_wait_counter #(
    parameter int CNT_W = 5
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic             load_i,
    input  logic [CNT_W-1:0] load_val_i,
    input  logic             dec_i,
    output logic             zero_o
);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (load_i) begin
            count_d = load_val_i;
        end else if (dec_i && (count_q != '0)) begin
            count_d = count_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign zero_o = (count_q == '0);

endmodule

// File: rtl/mc_ctrl_fsm.sv
// Multi-cycle control FSM: sequences FETCH/DECODE/EXEC/MEM/WB with memory
// handshakes and a timed MULT/DIV wait, driving the datapath enables.
module mc_ctrl_fsm
    import ctrl_pkg::*;
#(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       imem_ready,
    input  logic       dmem_ready,
    input  logic       cls_alu,
    input  logic       cls_load,
    input  logic       cls_store,
    input  logic       cls_branch,
    input  logic       cls_jal,
    input  logic       cls_jr,
    input  logic       cls_mult,
    input  logic       cls_div,
    input  logic       cls_mfhilo,
    input  logic       branch_taken,
    output logic       ir_write,
    output logic       pc_write,
    output logic [1:0] pc_src,
    output logic       grf_write,
    output logic       dm_read,
    output logic       dm_write,
    output logic       mdu_start,
    output logic       mdu_op,
    output logic       hilo_write,
    output logic [2:0] state,
    output logic       illegal
);

    localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CNT_W      = $clog2(MAX_CYCLES) + 1;

    state_t           state_q, state_d;
    logic [CLS_W-1:0] class_q, class_d;
    logic             illegal_q, illegal_d;
    logic [CLS_W-1:0] flags;

    logic             cnt_load, cnt_dec, cnt_zero;
    logic [CNT_W-1:0] cnt_load_val;

    logic             ir_write_c, pc_write_c, grf_write_c, dm_read_c, dm_write_c;
    logic             mdu_start_c, hilo_write_c;
    pc_src_t          pc_src_c;
    mdu_op_t          mdu_op_c;

    assign flags = {cls_mfhilo, cls_div, cls_mult, cls_jr, cls_jal,
                    cls_branch, cls_store, cls_load, cls_alu};

    always_comb begin
        state_d      = state_q;
        class_d      = class_q;
        illegal_d    = illegal_q;
        cnt_load     = 1'b0;
        cnt_load_val = '0;
        cnt_dec      = 1'b0;
        ir_write_c   = 1'b0;
        pc_write_c   = 1'b0;
        pc_src_c     = PC_SRC_PC4;
        grf_write_c  = 1'b0;
        dm_read_c    = 1'b0;
        dm_write_c   = 1'b0;
        mdu_start_c  = 1'b0;
        mdu_op_c     = MDU_OP_MULT;
        hilo_write_c = 1'b0;

        case (state_q)
            ST_FETCH: begin
                if (imem_ready) begin
                    ir_write_c = 1'b1;
                    pc_write_c = 1'b1;
                    state_d    = ST_DECODE;
                end
            end
            ST_DECODE: begin
                class_d = flags;
                if (!is_onehot(flags)) begin
                    state_d   = ST_TRAP;
                    illegal_d = 1'b1;
                end else if (cls_jal) begin
                    pc_write_c  = 1'b1;
                    pc_src_c    = PC_SRC_J;
                    grf_write_c = 1'b1;
                    state_d     = ST_FETCH;
                end else if (cls_jr) begin
                    pc_write_c = 1'b1;
                    pc_src_c   = PC_SRC_RS;
                    state_d    = ST_FETCH;
                end else begin
                    state_d = ST_EXEC;
                end
            end
            ST_EXEC: begin
                case (class_q)
                    cls_oh(CLS_ALU), cls_oh(CLS_MFHILO): state_d = ST_WB;
                    cls_oh(CLS_LOAD), cls_oh(CLS_STORE): state_d = ST_MEM;
                    cls_oh(CLS_BRANCH): begin
                        pc_write_c = branch_taken;
                        pc_src_c   = PC_SRC_BR;
                        state_d    = ST_FETCH;
                    end
                    // Counter is preloaded with N-1 so the MDU state lasts exactly N cycles.
                    cls_oh(CLS_MULT): begin
                        mdu_start_c  = 1'b1;
                        mdu_op_c     = MDU_OP_MULT;
                        cnt_load     = 1'b1;
                        cnt_load_val = CNT_W'(MULT_CYCLES - 1);
                        state_d      = ST_MDU;
                    end
                    cls_oh(CLS_DIV): begin
                        mdu_start_c  = 1'b1;
                        mdu_op_c     = MDU_OP_DIV;
                        cnt_load     = 1'b1;
                        cnt_load_val = CNT_W'(DIV_CYCLES - 1);
                        state_d      = ST_MDU;
                    end
                    default: begin
                        state_d   = ST_TRAP;
                        illegal_d = 1'b1;
                    end
                endcase
            end
            ST_MEM: begin
                if (class_q[CLS_LOAD]) begin
                    dm_read_c = 1'b1;
                    if (dmem_ready) state_d = ST_WB;
                end else if (class_q[CLS_STORE]) begin
                    dm_write_c = 1'b1;
                    if (dmem_ready) state_d = ST_FETCH;
                end else begin
                    state_d   = ST_TRAP;
                    illegal_d = 1'b1;
                end
            end
            ST_WB: begin
                grf_write_c = 1'b1;
                state_d     = ST_FETCH;
            end
            ST_MDU: begin
                if (cnt_zero) begin
                    hilo_write_c = 1'b1;
                    state_d      = ST_FETCH;
                end else begin
                    cnt_dec = 1'b1;
                end
            end
            ST_TRAP: illegal_d = 1'b1;
            default: begin
                state_d   = ST_TRAP;
                illegal_d = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= ST_FETCH;
            class_q   <= '0;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            class_q   <= class_d;
            illegal_q <= illegal_d;
        end
    end

    mdu_wait_counter #(
        .CNT_W(CNT_W)
    ) u_mdu_wait_counter (
        .clk_i      (clk),
        .rst_n_i    (reset),
        .load_i     (cnt_load),
        .load_val_i (cnt_load_val),
        .dec_i      (cnt_dec),
        .zero_o     (cnt_zero)
    );

    // FETCH decodes imem_ready combinationally, so gate everything while in reset.
    assign ir_write   = reset & ir_write_c;
    assign pc_write   = reset & pc_write_c;
    assign pc_src     = reset ? pc_src_c : PC_SRC_PC4;
    assign grf_write  = reset & grf_write_c;
    assign dm_read    = reset & dm_read_c;
    assign dm_write   = reset & dm_write_c;
    assign mdu_start  = reset & mdu_start_c;
    assign mdu_op     = reset ? mdu_op_c : MDU_OP_MULT;
    assign hilo_write = reset & hilo_write_c;
    assign state      = state_q;
    assign illegal    = reset & illegal_q;

endmodule
